clk_div_prog: RTL and testbench

Multi-channel, runtime-programmable integer clock divider. It generalises the fixed-N divider to CHANNELS independent dividers. Each channel has a software-loadable divisor with glitch-free period-boundary update, a per-channel enable, 50% duty for both odd and even N, and a single-cycle tick output. It sits between the 12 MHz board clock and the stopwatch/display timing logic, which use tick as a clock enable.

---
 rtl/clk_div_prog.sv | 138 +++++++++++++
 tb/tb_clk_div_prog.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_prog.sv
// Multi-channel runtime-programmable integer clock divider.
//
// Each channel divides clk by its active divisor N, producing a 50%-duty
// clkout (half-cycle resolution for odd N), a one-clk tick per period and a
// pending flag for a written-but-not-yet-applied divisor. New divisors land
// in a shadow register and only move to the active register at a period
// boundary, or at once while the channel is disabled, so no period is ever
// truncated or stretched.
//
// Ports:
//   clk      in   system clock, the only clock
//   rst_n    in   asynchronous active-low reset
//   en       in   [CHANNELS]  per-channel run enable
//   div_wr   in   single-cycle divisor write strobe
//   div_sel  in   [SELW]      channel index for div_wr
//   div_val  in   [WIDTH]     new divisor N (0 is rejected)
//   clkout   out  [CHANNELS]  divided clock
//   tick     out  [CHANNELS]  one-clk pulse per divided period
//   pending  out  [CHANNELS]  shadow divisor not yet active
//   err      out  one-clk pulse on a rejected write
module clk_div_prog #(
  parameter int unsigned  WIDTH       = 24,
  parameter int unsigned  CHANNELS    = 2,
  parameter int unsigned  DEFAULT_DIV = 1_200_000,
  localparam int unsigned SELW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] en,
  input  logic                div_wr,
  input  logic [SELW-1:0]     div_sel,
  input  logic [WIDTH-1:0]    div_val,
  output logic [CHANNELS-1:0] clkout,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] pending,
  output logic                err
);

  localparam logic [WIDTH-1:0] DefaultDiv = WIDTH'(DEFAULT_DIV);

  logic sel_ok;
  logic wr_ok;
  logic err_q, err_d;

  // With a power-of-two channel count every div_sel encoding is a real channel.
  if ((1 << SELW) > CHANNELS) begin : g_sel_chk
    assign sel_ok = (32'(div_sel) < CHANNELS);
  end else begin : g_sel_all
    assign sel_ok = 1'b1;
  end

  assign wr_ok = div_wr & sel_ok & (div_val != '0);

  always_comb begin
    err_d = div_wr & ~wr_ok;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] active_q, active_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic             pending_q, pending_d;
    logic             clk_p_q, clk_p_d;
    logic             clk_n_q, clk_n_d;
    logic             tick_q, tick_d;
    logic             wr_hit;
    logic             at_end;
    logic             apply;
    logic             bypass;
    logic             odd;

    assign wr_hit = wr_ok && (div_sel == SELW'(i));

    always_comb begin
      at_end    = (cnt_q == active_q - WIDTH'(1));
      // A disabled channel is idle, so a new divisor can take effect at once.
      apply     = ~en[i] | at_end;
      cnt_d     = '0;
      if (en[i] && !at_end) begin
        cnt_d = cnt_q + WIDTH'(1);
      end
      // On a write coinciding with a boundary the old shadow applies now and
      // the new value waits, still pending, for the next boundary.
      active_d  = apply ? shadow_q : active_q;
      shadow_d  = wr_hit ? div_val : shadow_q;
      pending_d = wr_hit ? 1'b1 : (apply ? 1'b0 : pending_q);
      clk_p_d   = en[i] & (cnt_q >= (active_q >> 1));
      tick_d    = en[i] & at_end;
      clk_n_d   = en[i] & clk_p_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q     <= '0;
        active_q  <= DefaultDiv;
        shadow_q  <= DefaultDiv;
        pending_q <= 1'b0;
        clk_p_q   <= 1'b0;
        tick_q    <= 1'b0;
      end else begin
        cnt_q     <= cnt_d;
        active_q  <= active_d;
        shadow_q  <= shadow_d;
        pending_q <= pending_d;
        clk_p_q   <= clk_p_d;
        tick_q    <= tick_d;
      end
    end

    // Half-cycle delayed copy; ANDing it with clk_p trims half a clock off the
    // high phase so odd divisors get a true 50% duty.
    always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
        clk_n_q <= 1'b0;
      end else begin
        clk_n_q <= clk_n_d;
      end
    end

    assign bypass = (active_q == WIDTH'(1));
    assign odd    = active_q[0];

    assign clkout[i]  = en[i] & (bypass ? clk : (odd ? (clk_p_q & clk_n_q) : clk_p_q));
    assign tick[i]    = tick_q;
    assign pending[i] = pending_q;
  end

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog: three channels, 8-bit divisors, reset
// divisor 4. A table of per-clock vectors covers the default waveform, a
// running divisor change and rejected writes; hand-written sequences cover
// odd divisors, the N==1 bypass and reset with a write pending.
module tb_clk_div_prog;

  localparam int unsigned W  = 8;
  localparam int unsigned CH = 3;
  localparam int unsigned SW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [CH-1:0] en;
  logic          div_wr;
  logic [SW-1:0] div_sel;
  logic [W-1:0]  div_val;
  logic [CH-1:0] clkout;
  logic [CH-1:0] tick;
  logic [CH-1:0] pending;
  logic          err;

  clk_div_prog #(
    .WIDTH      (W),
    .CHANNELS   (CH),
    .DEFAULT_DIV(4)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .div_wr (div_wr),
    .div_sel(div_sel),
    .div_val(div_val),
    .clkout (clkout),
    .tick   (tick),
    .pending(pending),
    .err    (err)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [CH-1:0] s_clk_hi, s_clk_lo, s_tick, s_pend;
  logic          s_err;

  typedef struct {
    logic [CH-1:0] en;
    logic          wr;
    logic [SW-1:0] sel;
    logic [W-1:0]  val;
    logic [CH-1:0] exp_clk;
    logic [CH-1:0] exp_tick;
    logic [CH-1:0] exp_pend;
    logic          exp_err;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [CH-1:0] e, input logic w, input logic [SW-1:0] s,
                     input logic [W-1:0] v, input logic [CH-1:0] ck, input logic [CH-1:0] tk,
                     input logic [CH-1:0] pd, input logic er);
    vec_t r;
    r.en = e; r.wr = w; r.sel = s; r.val = v;
    r.exp_clk = ck; r.exp_tick = tk; r.exp_pend = pd; r.exp_err = er;
    tbl.push_back(r);
  endtask

  task automatic chkv(input string name, input logic [CH-1:0] act, input logic [CH-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // Drive inputs, sample just after the posedge and just after the negedge.
  task automatic cycle(input logic [CH-1:0] e, input logic w, input logic [SW-1:0] s,
                       input logic [W-1:0] v);
    en = e; div_wr = w; div_sel = s; div_val = v;
    @(posedge clk); #1;
    s_clk_hi = clkout; s_tick = tick; s_pend = pending; s_err = err;
    @(negedge clk); #1;
    s_clk_lo = clkout;
    div_wr = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic found;

    //  en     wr    sel   val   clkout  tick    pend    err
    add(3'b111, 1'b0, 2'd0, 8'd0, 3'b000, 3'b000, 3'b000, 1'b0); // P1
    add(3'b111, 1'b0, 2'd0, 8'd0, 3'b000, 3'b000, 3'b000, 1'b0);
    add(3'b111, 1'b0, 2'd0, 8'd0, 3'b111, 3'b000, 3'b000, 1'b0); // first rise
    add(3'b111, 1'b0, 2'd0, 8'd0, 3'b111, 3'b111, 3'b000, 1'b0);
    add(3'b111, 1'b0, 2'd0, 8'd0, 3'b000, 3'b000, 3'b000, 1'b0); // P5
    add(3'b111, 1'b0, 2'd0, 8'd0, 3'b000, 3'b000, 3'b000, 1'b0);
    add(3'b111, 1'b0, 2'd0, 8'd0, 3'b111, 3'b000, 3'b000, 1'b0);
    add(3'b111, 1'b0, 2'd0, 8'd0, 3'b111, 3'b111, 3'b000, 1'b0);
    add(3'b111, 1'b0, 2'd0, 8'd0, 3'b000, 3'b000, 3'b000, 1'b0); // P9
    add(3'b111, 1'b1, 2'd0, 8'd6, 3'b000, 3'b000, 3'b001, 1'b0); // write 6 at cnt=1
    add(3'b111, 1'b0, 2'd0, 8'd0, 3'b111, 3'b000, 3'b001, 1'b0);
    add(3'b111, 1'b0, 2'd0, 8'd0, 3'b111, 3'b111, 3'b000, 1'b0); // boundary applies 6
    add(3'b111, 1'b0, 2'd0, 8'd0, 3'b000, 3'b000, 3'b000, 1'b0); // P13
    add(3'b111, 1'b0, 2'd0, 8'd0, 3'b000, 3'b000, 3'b000, 1'b0);
    add(3'b111, 1'b0, 2'd0, 8'd0, 3'b110, 3'b000, 3'b000, 1'b0);
    add(3'b111, 1'b0, 2'd0, 8'd0, 3'b111, 3'b110, 3'b000, 1'b0);
    add(3'b111, 1'b0, 2'd0, 8'd0, 3'b001, 3'b000, 3'b000, 1'b0); // P17
    add(3'b111, 1'b0, 2'd0, 8'd0, 3'b001, 3'b001, 3'b000, 1'b0);
    add(3'b111, 1'b0, 2'd0, 8'd0, 3'b110, 3'b000, 3'b000, 1'b0);
    add(3'b111, 1'b0, 2'd0, 8'd0, 3'b110, 3'b110, 3'b000, 1'b0);
    add(3'b111, 1'b0, 2'd0, 8'd0, 3'b000, 3'b000, 3'b000, 1'b0); // P21
    add(3'b111, 1'b0, 2'd0, 8'd0, 3'b001, 3'b000, 3'b000, 1'b0);
    add(3'b111, 1'b0, 2'd0, 8'd0, 3'b111, 3'b000, 3'b000, 1'b0);
    add(3'b111, 1'b0, 2'd0, 8'd0, 3'b111, 3'b111, 3'b000, 1'b0);
    add(3'b111, 1'b1, 2'd0, 8'd0, 3'b000, 3'b000, 3'b000, 1'b1); // P25 val=0 rejected
    add(3'b111, 1'b0, 2'd0, 8'd0, 3'b000, 3'b000, 3'b000, 1'b0);
    add(3'b111, 1'b1, 2'd3, 8'd5, 3'b110, 3'b000, 3'b000, 1'b1); // sel=3 rejected
    add(3'b111, 1'b0, 2'd0, 8'd0, 3'b111, 3'b110, 3'b000, 1'b0);
    add(3'b111, 1'b0, 2'd0, 8'd0, 3'b001, 3'b000, 3'b000, 1'b0); // P29
    add(3'b111, 1'b0, 2'd0, 8'd0, 3'b001, 3'b001, 3'b000, 1'b0);

    rst_n   = 1'b0;
    en      = 3'b111;
    div_wr  = 1'b0;
    div_sel = '0;
    div_val = '0;

    repeat (2) @(negedge clk);
    #1;
    chkv("reset clkout", clkout, 3'b000);
    chkv("reset tick", tick, 3'b000);
    chkv("reset pending", pending, 3'b000);
    chkb("reset err", err, 1'b0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      cycle(tbl[i].en, tbl[i].wr, tbl[i].sel, tbl[i].val);
      chkv($sformatf("row%0d clkout_hi", i + 1), s_clk_hi, tbl[i].exp_clk);
      chkv($sformatf("row%0d clkout_lo", i + 1), s_clk_lo, tbl[i].exp_clk);
      chkv($sformatf("row%0d tick", i + 1), s_tick, tbl[i].exp_tick);
      chkv($sformatf("row%0d pending", i + 1), s_pend, tbl[i].exp_pend);
      chkb($sformatf("row%0d err", i + 1), s_err, tbl[i].exp_err);
    end

    // Odd divisor: load N=5 into ch0 while disabled, then enable.
    cycle(3'b110, 1'b0, 2'd0, 8'd0);
    chkb("odd: clkout0 gated by en", s_clk_lo[0], 1'b0);
    cycle(3'b110, 1'b1, 2'd0, 8'd5);
    chkb("odd: pending0 after write", s_pend[0], 1'b1);
    cycle(3'b110, 1'b0, 2'd0, 8'd0);
    chkb("odd: pending0 applied while disabled", s_pend[0], 1'b0);
    chkb("odd: clkout0 idle", s_clk_hi[0], 1'b0);
    chkb("odd: tick0 idle", s_tick[0], 1'b0);
    for (int j = 0; j < 20; j++) begin
      cycle(3'b111, 1'b0, 2'd0, 8'd0);
      // Half-cycle index 2j / 2j+1; high for 5 halves out of every 10.
      chkb($sformatf("odd: clkout0 half %0d", 2 * j), s_clk_hi[0], ((2 * j) % 10) >= 5);
      chkb($sformatf("odd: clkout0 half %0d", 2 * j + 1), s_clk_lo[0],
           ((2 * j + 1) % 10) >= 5);
      chkb($sformatf("odd: tick0 clk %0d", j), s_tick[0], (j % 5) == 4);
    end

    // N=1 bypass on ch1, then disable it.
    cycle(3'b111, 1'b1, 2'd1, 8'd1);
    chkb("n1: pending1 after write", s_pend[1], 1'b1);
    found = 1'b0;
    for (int j = 0; j < 6; j++) begin
      cycle(3'b111, 1'b0, 2'd0, 8'd0);
      if (s_pend[1] == 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    chkb("n1: pending1 cleared within bound", found, 1'b1);
    for (int j = 0; j < 4; j++) begin
      if (j > 0) cycle(3'b111, 1'b0, 2'd0, 8'd0);
      chkb($sformatf("n1: clkout1 high phase %0d", j), s_clk_hi[1], 1'b1);
      chkb($sformatf("n1: clkout1 low phase %0d", j), s_clk_lo[1], 1'b0);
      chkb($sformatf("n1: tick1 held %0d", j), s_tick[1], 1'b1);
    end
    for (int j = 0; j < 2; j++) begin
      cycle(3'b101, 1'b0, 2'd0, 8'd0);
      chkb($sformatf("n1 off: clkout1 hi %0d", j), s_clk_hi[1], 1'b0);
      chkb($sformatf("n1 off: clkout1 lo %0d", j), s_clk_lo[1], 1'b0);
      chkb($sformatf("n1 off: tick1 %0d", j), s_tick[1], 1'b0);
    end

    // Reset mid-period with a write pending on ch0.
    cycle(3'b101, 1'b1, 2'd0, 8'd7);
    chkb("rst: pending0 before reset", s_pend[0], 1'b1);
    rst_n = 1'b0;
    #1;
    chkv("rst: async clkout", clkout, 3'b000);
    chkv("rst: async tick", tick, 3'b000);
    chkv("rst: async pending", pending, 3'b000);
    chkb("rst: async err", err, 1'b0);
    @(posedge clk); #1;
    chkv("rst: held clkout", clkout, 3'b000);
    en = 3'b111;
    @(negedge clk); #1;
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      cycle(3'b111, 1'b0, 2'd0, 8'd0);
      chkv($sformatf("post-rst P%0d clkout_hi", k), s_clk_hi,
           (((k - 1) % 4) >= 2) ? 3'b111 : 3'b000);
      chkv($sformatf("post-rst P%0d clkout_lo", k), s_clk_lo,
           (((k - 1) % 4) >= 2) ? 3'b111 : 3'b000);
      chkv($sformatf("post-rst P%0d tick", k), s_tick,
           (((k - 1) % 4) == 3) ? 3'b111 : 3'b000);
      chkv($sformatf("post-rst P%0d pending", k), s_pend, 3'b000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
